// File: rtl/axil_traffic_gen_if.sv
// ---------------------------------------------------------------------------
// axil_traffic_gen_if
// AXI4-Lite bus bundle used between the traffic generator (master) and the
// target register bank (slave).
//   ADDR_W : address width
//   DATA_W : data width (WSTRB is DATA_W/8 bits)
// Modports:
//   master : drives AW/W/AR channels and BREADY/RREADY
//   slave  : drives the READY signals of AW/W/AR and the B/R channels
// ---------------------------------------------------------------------------
interface axil_traffic_gen_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_traffic_gen.sv
// ---------------------------------------------------------------------------
// axil_traffic_gen
// AXI4-Lite master traffic generator and self-checker. A rising edge on
// INIT_AXI_TXN starts a run of C_M_TRANSACTIONS_NUM single-beat writes of
// the pattern SEED+i to BASE+i*STRIDE, followed (mode 0) by read-back and
// compare. Mode 1 only writes, mode 2 only reads and compares.
//
// Ports:
//   M_AXI_ACLK    clock
//   M_AXI_ARESET  synchronous active-high reset
//   INIT_AXI_TXN  start request (rising edge)
//   TXN_DONE      high from run completion until next start / reset
//   ERROR         sticky: any bad response, data mismatch or timeout
//   ERR_COUNT     saturating count of error events
//   m_axi         AXI4-Lite master bundle (axil_traffic_gen_if.master)
//
// Optional build macro AXIL_TRAFFIC_GEN_TIMEOUT_EN adds a handshake
// watchdog of C_M_TIMEOUT cycles that aborts the run to DONE.
// ---------------------------------------------------------------------------
module axil_traffic_gen #(
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
  parameter int          C_M_AXI_ADDR_WIDTH         = 32,
  parameter int          C_M_AXI_DATA_WIDTH         = 32,
  parameter int          C_M_TRANSACTIONS_NUM       = 4,
  parameter int          C_M_ADDR_STRIDE            = 4,
  parameter int          C_M_MODE                   = 0,
  parameter logic [31:0] C_M_DATA_SEED              = 32'h0101_FFFF,
  parameter int          C_M_TIMEOUT                = 256
) (
  input  logic                M_AXI_ACLK,
  input  logic                M_AXI_ARESET,
  input  logic                INIT_AXI_TXN,
  output logic                TXN_DONE,
  output logic                ERROR,
  output logic [15:0]         ERR_COUNT,
  axil_traffic_gen_if.master  m_axi
);

  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int DW    = C_M_AXI_DATA_WIDTH;
  localparam int IDX_W = (C_M_TRANSACTIONS_NUM > 1) ? $clog2(C_M_TRANSACTIONS_NUM) : 1;
  localparam logic [AW-1:0]    BASE   = AW'(C_M_TARGET_SLAVE_BASE_ADDR);
  localparam logic [AW-1:0]    STRIDE = AW'(C_M_ADDR_STRIDE);
  localparam logic [DW-1:0]    SEED   = DW'(C_M_DATA_SEED);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(C_M_TRANSACTIONS_NUM - 1);

  if ((DW != 32 && DW != 64) || C_M_TRANSACTIONS_NUM < 1 || C_M_TRANSACTIONS_NUM > 1024 ||
      (C_M_ADDR_STRIDE % (DW / 8)) != 0 || C_M_MODE < 0 || C_M_MODE > 2 ||
      C_M_TIMEOUT < 1) begin : g_bad_params
    $error("axil_traffic_gen: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             init_q, init_prev_q;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [15:0]      errc_q, errc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    pat_q, pat_d;
  logic             awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic             arvalid_q, arvalid_d, rready_q, rready_d;
  logic             start, aw_hs, w_hs, b_hs, ar_hs, r_hs, pair_done;

`ifdef AXIL_TRAFFIC_GEN_TIMEOUT_EN
  localparam int WD_W = $clog2(C_M_TIMEOUT + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            waiting, progress;
`endif

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign start = init_q & ~init_prev_q;
  assign aw_hs = awvalid_q & m_axi.awready;
  assign w_hs  = wvalid_q & m_axi.wready;
  assign b_hs  = bready_q & m_axi.bvalid;
  assign ar_hs = arvalid_q & m_axi.arready;
  assign r_hs  = rready_q & m_axi.rvalid;
  // The last of the AW/W pair completes this cycle (either may finish first).
  assign pair_done = (state_q == S_WR) && (awvalid_q || wvalid_q) &&
                     (!awvalid_q || m_axi.awready) && (!wvalid_q || m_axi.wready);

  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    error_d   = error_q;
    errc_d    = errc_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    pat_d     = pat_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          errc_d  = 16'd0;
          idx_d   = '0;
          addr_d  = BASE;
          pat_d   = SEED;
          if (C_M_MODE == 2) begin
            state_d   = S_RD;
            arvalid_d = 1'b1;
          end else begin
            state_d   = S_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end
        end
      end
      S_WR: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (pair_done) bready_d = 1'b1;
        if (b_hs) begin
          bready_d = 1'b0;
          if (m_axi.bresp != 2'b00) begin
            error_d = 1'b1;
            errc_d  = sat_inc(errc_q);
          end
          if (idx_q == LAST) begin
            idx_d  = '0;
            addr_d = BASE;
            pat_d  = SEED;
            if (C_M_MODE == 0) begin
              state_d   = S_RD;
              arvalid_d = 1'b1;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            addr_d    = addr_q + STRIDE;
            pat_d     = pat_q + DW'(1);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end
        end
      end
      S_RD: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
        if (r_hs) begin
          rready_d = 1'b0;
          // A bad response and a data mismatch on one beat count once.
          if (m_axi.rresp != 2'b00 || m_axi.rdata != pat_q) begin
            error_d = 1'b1;
            errc_d  = sat_inc(errc_q);
          end
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            addr_d    = addr_q + STRIDE;
            pat_d     = pat_q + DW'(1);
            arvalid_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef AXIL_TRAFFIC_GEN_TIMEOUT_EN
    // AW and W are one request: the watchdog restarts when the pair is
    // complete, not when only one half of it has been accepted.
    waiting  = awvalid_q | wvalid_q | bready_q | arvalid_q | rready_q;
    progress = pair_done | b_hs | ar_hs | r_hs;
    wdog_d   = wdog_q + WD_W'(1);
    if (!waiting || progress) begin
      wdog_d = '0;
    end else if (wdog_q == WD_W'(C_M_TIMEOUT - 1)) begin
      wdog_d    = '0;
      error_d   = 1'b1;
      errc_d    = sat_inc(errc_q);
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      idx_d     = '0;
      state_d   = S_DONE;
      done_d    = 1'b1;
    end
`endif
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q     <= S_IDLE;
      init_q      <= 1'b0;
      init_prev_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      errc_q      <= 16'd0;
      idx_q       <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
`ifdef AXIL_TRAFFIC_GEN_TIMEOUT_EN
      wdog_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      init_q      <= INIT_AXI_TXN;
      init_prev_q <= init_q;
      done_q      <= done_d;
      error_q     <= error_d;
      errc_q      <= errc_d;
      idx_q       <= idx_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
`ifdef AXIL_TRAFFIC_GEN_TIMEOUT_EN
      wdog_q      <= wdog_d;
`endif
    end
    // Address and pattern are only meaningful while a VALID is up.
    addr_q <= addr_d;
    pat_q  <= pat_d;
  end

  assign TXN_DONE      = done_q;
  assign ERROR         = error_q;
  assign ERR_COUNT     = errc_q;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = pat_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_axil_traffic_gen.sv
// ---------------------------------------------------------------------------
// tb_axil_traffic_gen
// Three generator instances, each with its own memory-backed AXI4-Lite slave:
//   dut 0 : mode 0 (write + read/compare), N = 4
//   dut 1 : mode 1 (write only),           N = 3
//   dut 2 : mode 0,                        N = 16
// The slaves can insert random ready/response delays, corrupt one read word,
// return SLVERR on one write, or hold AWREADY low.
// ---------------------------------------------------------------------------
module tb_axil_traffic_gen;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] SEED = 32'h0101_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst, init, done, err;
  logic [15:0] errc [3];
  logic [2:0]  awv_w, wv_w, br_w, arv_w, rr_w;
  int          aw_cnt_w [3];
  int          ar_cnt_w [3];
  int          viol_w [3];
  logic [2:0]  rnd, aw_stuck, chk_en;
  int          corrupt [3];
  int          bresp_bad [3];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : gs
    localparam int N    = (g == 1) ? 3 : ((g == 2) ? 16 : 4);
    localparam int MODE = (g == 1) ? 1 : 0;

    axil_traffic_gen_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axil_traffic_gen #(
      .C_M_TARGET_SLAVE_BASE_ADDR(BASE),
      .C_M_AXI_ADDR_WIDTH(32),
      .C_M_AXI_DATA_WIDTH(32),
      .C_M_TRANSACTIONS_NUM(N),
      .C_M_ADDR_STRIDE(4),
      .C_M_MODE(MODE),
      .C_M_DATA_SEED(SEED),
      .C_M_TIMEOUT(16)
    ) dut (
      .M_AXI_ACLK(clk),
      .M_AXI_ARESET(rst[g]),
      .INIT_AXI_TXN(init[g]),
      .TXN_DONE(done[g]),
      .ERROR(err[g]),
      .ERR_COUNT(errc[g]),
      .m_axi(bus)
    );

    logic [31:0] mem [16];
    logic [31:0] aw_log [16];
    logic        have_aw, have_w, b_pend, r_pend, b_bad;
    logic [31:0] aw_a, w_d, ar_a;
    int          aw_dly, w_dly, ar_dly, b_dly, r_dly;
    int          aw_cnt = 0;
    int          ar_cnt = 0;
    int          viol = 0;
    logic        hold_aw, hold_w, hold_ar;

    assign awv_w[g]    = bus.awvalid;
    assign wv_w[g]     = bus.wvalid;
    assign br_w[g]     = bus.bready;
    assign arv_w[g]    = bus.arvalid;
    assign rr_w[g]     = bus.rready;
    assign aw_cnt_w[g] = aw_cnt;
    assign ar_cnt_w[g] = ar_cnt;
    assign viol_w[g]   = viol;

    always @(posedge clk) begin
      if (rst[g]) begin
        bus.awready <= 1'b0; bus.wready <= 1'b0; bus.arready <= 1'b0;
        bus.bvalid  <= 1'b0; bus.rvalid <= 1'b0;
        bus.bresp   <= 2'b00; bus.rresp <= 2'b00; bus.rdata <= 32'd0;
        have_aw <= 1'b0; have_w <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0; b_bad <= 1'b0;
        aw_dly <= 0; w_dly <= 0; ar_dly <= 0; b_dly <= 0; r_dly <= 0;
        hold_aw <= 1'b0; hold_w <= 1'b0; hold_ar <= 1'b0;
      end else begin
        // VALID must stay up until its handshake.
        if (chk_en[g]) begin
          if (hold_aw && !bus.awvalid) viol <= viol + 1;
          if (hold_w  && !bus.wvalid)  viol <= viol + 1;
          if (hold_ar && !bus.arvalid) viol <= viol + 1;
        end
        hold_aw <= bus.awvalid && !bus.awready;
        hold_w  <= bus.wvalid  && !bus.wready;
        hold_ar <= bus.arvalid && !bus.arready;

        if (!rnd[g]) bus.awready <= !aw_stuck[g];
        else if (bus.awvalid && bus.awready) begin bus.awready <= 1'b0; aw_dly <= $urandom_range(0, 7); end
        else if (bus.awvalid) begin if (aw_dly == 0) bus.awready <= 1'b1; else aw_dly <= aw_dly - 1; end

        if (!rnd[g]) bus.wready <= 1'b1;
        else if (bus.wvalid && bus.wready) begin bus.wready <= 1'b0; w_dly <= $urandom_range(0, 7); end
        else if (bus.wvalid) begin if (w_dly == 0) bus.wready <= 1'b1; else w_dly <= w_dly - 1; end

        if (!rnd[g]) bus.arready <= 1'b1;
        else if (bus.arvalid && bus.arready) begin bus.arready <= 1'b0; ar_dly <= $urandom_range(0, 7); end
        else if (bus.arvalid) begin if (ar_dly == 0) bus.arready <= 1'b1; else ar_dly <= ar_dly - 1; end

        if (bus.awvalid && bus.awready) begin have_aw <= 1'b1; aw_a <= bus.awaddr; aw_cnt <= aw_cnt + 1; end
        if (bus.wvalid && bus.wready) begin have_w <= 1'b1; w_d <= bus.wdata; end
        if (have_aw && have_w) begin
          mem[aw_a[5:2]]    <= w_d;
          aw_log[aw_a[5:2]] <= aw_a;
          have_aw <= 1'b0;
          have_w  <= 1'b0;
          b_pend  <= 1'b1;
          b_bad   <= (int'(aw_a[5:2]) == bresp_bad[g]);
          b_dly   <= rnd[g] ? int'($urandom_range(0, 7)) : 0;
        end
        if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
        if (b_pend) begin
          if (b_dly == 0) begin
            bus.bvalid <= 1'b1;
            bus.bresp  <= b_bad ? 2'b10 : 2'b00;
            b_pend     <= 1'b0;
          end else b_dly <= b_dly - 1;
        end

        if (bus.arvalid && bus.arready) begin
          ar_a   <= bus.araddr;
          r_pend <= 1'b1;
          r_dly  <= rnd[g] ? int'($urandom_range(0, 7)) : 0;
          ar_cnt <= ar_cnt + 1;
        end
        if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
        if (r_pend) begin
          if (r_dly == 0) begin
            bus.rvalid <= 1'b1;
            bus.rresp  <= 2'b00;
            bus.rdata  <= (int'(ar_a[5:2]) == corrupt[g]) ? 32'hDEAD_0011 : mem[ar_a[5:2]];
            r_pend     <= 1'b0;
          end else r_dly <= r_dly - 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_init(input int d);
    init[d] = 1'b1;
    @(negedge clk);
    init[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 4000 && !done[d]; k++) @(negedge clk);
    vectors++;
    if (!done[d]) begin
      miscompares++;
      $display("FAIL run_budget dut%0d: TXN_DONE got 0, expected 1 within 4000 cycles", d);
    end
  endtask

  function automatic logic [31:0] status(input int d);
    return {25'd0, awv_w[d], wv_w[d], br_w[d], arv_w[d], rr_w[d], done[d], err[d]};
  endfunction

  typedef struct {
    string       name;
    int          d;
    logic        r;
    int          bad_word;
    int          bad_b;
    logic [31:0] exp_err;
    logic [31:0] exp_cnt;
    int          exp_aw;
    int          exp_ar;
  } vec_t;

  vec_t vt [6];

  initial begin
    int aw0, ar0, t0, total;
    rst = '1; init = '0; rnd = '0; aw_stuck = '0; chk_en = '1;
    corrupt   = '{-1, -1, -1};
    bresp_bad = '{-1, -1, -1};

    vt[0] = '{"m0_n4_clean",        0, 1'b0, -1, -1, 32'd0, 32'd0,  4,  4};
    vt[1] = '{"m0_n4_corrupt_w2",   0, 1'b0,  2, -1, 32'd1, 32'd1,  4,  4};
    vt[2] = '{"m1_n3_slverr_w0",    1, 1'b0, -1,  0, 32'd1, 32'd1,  3,  0};
    vt[3] = '{"m0_n16_random",      2, 1'b1, -1, -1, 32'd0, 32'd0, 16, 16};
    vt[4] = '{"m0_n16_rand_corr5",  2, 1'b1,  5, -1, 32'd1, 32'd1, 16, 16};
    vt[5] = '{"m1_n3_clean",        1, 1'b0, -1, -1, 32'd0, 32'd0,  3,  0};

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_status_dut%0d", d), status(d), 32'd0);
      check($sformatf("reset_errcount_dut%0d", d), {16'd0, errc[d]}, 32'd0);
    end
    rst = '0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      int d;
      d = vt[i].d;
      rnd[d] = vt[i].r;
      corrupt[d] = vt[i].bad_word;
      bresp_bad[d] = vt[i].bad_b;
      aw0 = aw_cnt_w[d];
      ar0 = ar_cnt_w[d];
      pulse_init(d);
      wait_done(d);
      check({vt[i].name, "_done"},   {31'd0, done[d]}, 32'd1);
      check({vt[i].name, "_error"},  {31'd0, err[d]}, vt[i].exp_err);
      check({vt[i].name, "_errcnt"}, {16'd0, errc[d]}, vt[i].exp_cnt);
      check({vt[i].name, "_aw"},     aw_cnt_w[d] - aw0, vt[i].exp_aw);
      check({vt[i].name, "_ar"},     ar_cnt_w[d] - ar0, vt[i].exp_ar);
      rnd[d] = 1'b0; corrupt[d] = -1; bresp_bad[d] = -1;
    end

    for (int i = 0; i < 4; i++) begin
      check($sformatf("dut0_mem%0d", i), gs[0].mem[i], SEED + 32'(i));
      check($sformatf("dut0_awaddr%0d", i), gs[0].aw_log[i], BASE + 32'(4 * i));
    end
    check("dut2_mem15", gs[2].mem[15], 32'h0102_000E);
    check("dut1_mem2",  gs[1].mem[2],  32'h0102_0001);
    check("prot_strb",  {21'd0, gs[0].bus.awprot, gs[0].bus.arprot, 1'b0, gs[0].bus.wstrb}, 32'h0000_000F);

    // A second start while the run is in progress must not restart it.
    aw0 = aw_cnt_w[0];
    ar0 = ar_cnt_w[0];
    pulse_init(0);
    repeat (3) @(negedge clk);
    pulse_init(0);
    wait_done(0);
    check("busy_start_aw",     aw_cnt_w[0] - aw0, 32'd4);
    check("busy_start_ar",     ar_cnt_w[0] - ar0, 32'd4);
    check("busy_start_errcnt", {16'd0, errc[0]}, 32'd0);

    // Reset in the middle of the read phase, then a clean rerun.
    ar0 = ar_cnt_w[0];
    pulse_init(0);
    for (int k = 0; k < 200 && (ar_cnt_w[0] - ar0) < 3; k++) @(negedge clk);
    check("midrd_reached_beat2", ar_cnt_w[0] - ar0, 32'd3);
    rst[0] = 1'b1;
    @(negedge clk);
    check("midrd_reset_status", status(0), 32'd0);
    check("midrd_reset_errcnt", {16'd0, errc[0]}, 32'd0);
    rst[0] = 1'b0;
    @(negedge clk);
    aw0 = aw_cnt_w[0];
    ar0 = ar_cnt_w[0];
    pulse_init(0);
    wait_done(0);
    check("rerun_error",  {31'd0, err[0]}, 32'd0);
    check("rerun_errcnt", {16'd0, errc[0]}, 32'd0);
    check("rerun_aw",     aw_cnt_w[0] - aw0, 32'd4);
    check("rerun_ar",     ar_cnt_w[0] - ar0, 32'd4);

    total = viol_w[0] + viol_w[1] + viol_w[2];
    check("valid_held_until_handshake", total, 32'd0);

`ifdef AXIL_TRAFFIC_GEN_TIMEOUT_EN
    chk_en[0] = 1'b0;
    aw_stuck[0] = 1'b1;
    @(negedge clk);
    pulse_init(0);
    t0 = -1;
    for (int k = 0; k < 20; k++) begin
      if (awv_w[0]) begin t0 = cyc; break; end
      @(negedge clk);
    end
    check("timeout_awvalid_rose", {31'd0, awv_w[0]}, 32'd1);
    for (int k = 0; k < 100 && !done[0]; k++) @(negedge clk);
    check("timeout_cycles",  cyc - t0, 32'd16);
    check("timeout_done",    {31'd0, done[0]}, 32'd1);
    check("timeout_error",   {31'd0, err[0]}, 32'd1);
    check("timeout_errcnt",  {16'd0, errc[0]}, 32'd1);
    check("timeout_dropped", {29'd0, awv_w[0], wv_w[0], br_w[0]}, 32'd0);
    aw_stuck[0] = 1'b0;
`else
    t0 = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
